// File: rtl/lcd_timing_gen_if.sv
//----------------------------------------------------------------------------
// Module  : lcd_timing_gen_if
// Brief   : Pixel request/answer bus and panel outputs of the LCD raster stage.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface lcd_timing_gen_if;
  logic [23:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos,
    output pixel_ypos,
    output h_disp,
    output v_disp,
    output lcd_hs,
    output lcd_vs,
    output lcd_de,
    output lcd_rgb,
    output frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos,
    input  pixel_ypos,
    input  h_disp,
    input  v_disp,
    input  lcd_hs,
    input  lcd_vs,
    input  lcd_de,
    input  lcd_rgb,
    input  frame_start
  );
endinterface

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
//----------------------------------------------------------------------------
// Module  : lcd_timing_gen
// Brief   : Free-running raster timing generator and RGB output stage.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module lcd_timing_gen #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  lcd_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [10:0] c_h_last      = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_v_last      = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_h_sync      = 11'(H_SYNC);
  localparam logic [10:0] c_v_sync      = 11'(V_SYNC);
  localparam logic [10:0] c_de_h_start  = 11'(HA);
  localparam logic [10:0] c_de_h_end    = 11'(HA + H_DISP);
  localparam logic [10:0] c_req_h_start = 11'(HA - 1);
  localparam logic [10:0] c_req_h_end   = 11'(HA + H_DISP - 1);
  localparam logic [10:0] c_v_start     = 11'(VA);
  localparam logic [10:0] c_v_end       = 11'(VA + V_DISP);

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_frame_start;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_vact;
  logic        w_de_pre;
  logic        w_req;

  assign w_h_last = (r_h_cnt == c_h_last);
  assign w_v_last = (r_v_cnt == c_v_last);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  assign w_vact   = (r_v_cnt >= c_v_start) && (r_v_cnt < c_v_end);
  assign w_de_pre = w_vact && (r_h_cnt >= c_de_h_start) && (r_h_cnt < c_de_h_end);
  // Request window leads DE by one cycle so the image stage can register its answer.
  assign w_req    = w_vact && (r_h_cnt >= c_req_h_start) && (r_h_cnt < c_req_h_end);

  assign bus.pixel_xpos = w_req ? (r_h_cnt - c_req_h_start) : 11'd0;
  assign bus.pixel_ypos = w_req ? (r_v_cnt - c_v_start)     : 11'd0;
  assign bus.h_disp     = 11'(H_DISP);
  assign bus.v_disp     = 11'(V_DISP);

  // All panel signals share one register stage to keep sync-to-DE spacing exact.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= 24'h0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= (r_h_cnt >= c_h_sync);
      r_vs          <= (r_v_cnt >= c_v_sync);
      r_de          <= w_de_pre;
      r_rgb         <= w_de_pre ? bus.pixel_data : 24'h0;
      r_frame_start <= w_h_last && w_v_last;
    end
  end

  assign bus.lcd_hs      = r_hs;
  assign bus.lcd_vs      = r_vs;
  assign bus.lcd_de      = r_de;
  assign bus.lcd_rgb     = r_rgb;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
//----------------------------------------------------------------------------
// Module  : tb_lcd_timing_gen
// Brief   : Self-checking bench for lcd_timing_gen, default and small rasters.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_lcd_timing_gen;

  typedef struct {
    int hsync, hback, hdisp, hfront, vsync, vback, vdisp, vfront;
  } cfg_t;

  typedef struct {
    logic [31:0] hs, vs, de, rgb, fs, x, y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_def_n;
  logic rst_sml_n;

  always #5 clk = ~clk;

  lcd_timing_gen_if bus_def ();
  lcd_timing_gen_if bus_sml ();

  lcd_timing_gen dut_def (
    .lcd_pclk (clk),
    .rst_n    (rst_def_n),
    .bus      (bus_def)
  );

  lcd_timing_gen #(
    .H_SYNC (4), .H_BACK (2), .H_DISP (8), .H_FRONT (2),
    .V_SYNC (1), .V_BACK (1), .V_DISP (4), .V_FRONT (1)
  ) dut_sml (
    .lcd_pclk (clk),
    .rst_n    (rst_sml_n),
    .bus      (bus_sml)
  );

  int n_chk  = 0;
  int n_fail = 0;

  cfg_t cfg_def, cfg_sml;
  int   k_def, k_sml;
  logic [23:0] pend_def, pend_sml;
  logic [1:0]  used_def, used_sml;

  int   hs_run, since_fall, de_run;
  logic prev_hs, prev_de;
  int   sml_gap, sml_de, sml_vsl;
  bit   sml_seen;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Expected outputs after k clock edges since reset release, from absolute time.
  function automatic exp_t model(input cfg_t c, input int k, input logic [1:0] tag);
    exp_t e;
    int ht, vt, f, ha, va, p, hp, vp, cur, hc, vc;
    logic de, req;
    logic [23:0] pix;
    ht = c.hsync + c.hback + c.hdisp + c.hfront;
    vt = c.vsync + c.vback + c.vdisp + c.vfront;
    f  = ht * vt;
    ha = c.hsync + c.hback;
    va = c.vsync + c.vback;
    e  = '{hs: 32'd1, vs: 32'd1, de: 32'd0, rgb: 32'd0, fs: 32'd0, x: 32'd0, y: 32'd0};
    if (k == 0) return e;
    p  = (k - 1) % f;
    hp = p % ht;
    vp = p / ht;
    de = (vp >= va) && (vp < va + c.vdisp) && (hp >= ha) && (hp < ha + c.hdisp);
    e.hs = 32'(hp >= c.hsync);
    e.vs = 32'(vp >= c.vsync);
    e.de = 32'(de);
    e.fs = 32'(p == f - 1);
    if (de) begin
      pix   = {tag, 11'(vp - va), 11'(hp - ha)};
      e.rgb = 32'(pix);
    end
    cur = k % f;
    hc  = cur % ht;
    vc  = cur / ht;
    req = (vc >= va) && (vc < va + c.vdisp) && (hc >= ha - 1) && (hc < ha + c.hdisp - 1);
    if (req) begin
      e.x = 32'(hc - (ha - 1));
      e.y = 32'(vc - va);
    end
    return e;
  endfunction

  task automatic check_inst(input string nm, input cfg_t c, input int k, input logic [1:0] tag,
                            input logic hs, input logic vs, input logic de, input logic [23:0] rgb,
                            input logic fs, input logic [10:0] x, input logic [10:0] y,
                            input logic [10:0] hd, input logic [10:0] vd);
    exp_t e;
    e = model(c, k, tag);
    chk({nm, ".lcd_hs"},      32'(hs),  e.hs);
    chk({nm, ".lcd_vs"},      32'(vs),  e.vs);
    chk({nm, ".lcd_de"},      32'(de),  e.de);
    chk({nm, ".lcd_rgb"},     32'(rgb), e.rgb);
    chk({nm, ".frame_start"}, 32'(fs),  e.fs);
    chk({nm, ".pixel_xpos"},  32'(x),   e.x);
    chk({nm, ".pixel_ypos"},  32'(y),   e.y);
    chk({nm, ".h_disp"},      32'(hd),  32'(c.hdisp));
    chk({nm, ".v_disp"},      32'(vd),  32'(c.vdisp));
  endtask

  task automatic check_reset_now(input string nm, input logic hs, input logic vs, input logic de,
                                 input logic [23:0] rgb, input logic fs,
                                 input logic [10:0] x, input logic [10:0] y);
    chk({nm, ".async_hs"},  32'(hs),  32'd1);
    chk({nm, ".async_vs"},  32'(vs),  32'd1);
    chk({nm, ".async_de"},  32'(de),  32'd0);
    chk({nm, ".async_rgb"}, 32'(rgb), 32'd0);
    chk({nm, ".async_fs"},  32'(fs),  32'd0);
    chk({nm, ".async_x"},   32'(x),   32'd0);
    chk({nm, ".async_y"},   32'(y),   32'd0);
  endtask

  // One clock: apply image-stage answer after the edge, check on the falling edge.
  task automatic step();
    @(posedge clk);
    used_def = bus_def.pixel_data[23:22];
    used_sml = bus_sml.pixel_data[23:22];
    k_def = rst_def_n ? k_def + 1 : 0;
    k_sml = rst_sml_n ? k_sml + 1 : 0;
    #1;
    bus_def.pixel_data = pend_def;
    bus_sml.pixel_data = pend_sml;
    @(negedge clk);
    check_inst("def", cfg_def, k_def, used_def, bus_def.lcd_hs, bus_def.lcd_vs, bus_def.lcd_de,
               bus_def.lcd_rgb, bus_def.frame_start, bus_def.pixel_xpos, bus_def.pixel_ypos,
               bus_def.h_disp, bus_def.v_disp);
    check_inst("sml", cfg_sml, k_sml, used_sml, bus_sml.lcd_hs, bus_sml.lcd_vs, bus_sml.lcd_de,
               bus_sml.lcd_rgb, bus_sml.frame_start, bus_sml.pixel_xpos, bus_sml.pixel_ypos,
               bus_sml.h_disp, bus_sml.v_disp);

    if (k_def == 0) begin
      hs_run = 0; since_fall = -1; de_run = 0; prev_hs = 1'b1; prev_de = 1'b0;
    end else begin
      if (!bus_def.lcd_hs) hs_run++;
      if (bus_def.lcd_hs && !prev_hs) begin
        chk("def_hs_low_len", 32'(hs_run), 32'd128);
        hs_run = 0;
      end
      if (!bus_def.lcd_hs && prev_hs) since_fall = 0;
      else if (since_fall >= 0) since_fall++;
      if (bus_def.lcd_de && !prev_de) chk("def_de_after_hs_fall", 32'(since_fall), 32'd216);
      if (bus_def.lcd_de) de_run++;
      if (!bus_def.lcd_de && prev_de) begin
        chk("def_de_len", 32'(de_run), 32'd800);
        de_run = 0;
      end
      prev_hs = bus_def.lcd_hs;
      prev_de = bus_def.lcd_de;
    end

    if (k_sml == 0) begin
      sml_seen = 1'b0; sml_gap = 0; sml_de = 0; sml_vsl = 0;
    end else begin
      sml_gap++;
      if (bus_sml.lcd_de) sml_de++;
      if (!bus_sml.lcd_vs) sml_vsl++;
      if (bus_sml.frame_start) begin
        if (sml_seen) begin
          chk("sml_frame_period", 32'(sml_gap), 32'd112);
          chk("sml_de_per_frame", 32'(sml_de),  32'd32);
          chk("sml_vs_low_len",   32'(sml_vsl), 32'd16);
        end
        sml_seen = 1'b1; sml_gap = 0; sml_de = 0; sml_vsl = 0;
      end
    end

    pend_def = {2'($urandom_range(0, 3)), bus_def.pixel_ypos, bus_def.pixel_xpos};
    pend_sml = {2'($urandom_range(0, 3)), bus_sml.pixel_ypos, bus_sml.pixel_xpos};
  endtask

  initial begin
    int  hold;
    int  n;
    bit  found;
    bit  rose;

    cfg_def = '{128, 88, 800, 40, 2, 33, 480, 10};
    cfg_sml = '{4, 2, 8, 2, 1, 1, 4, 1};
    rst_def_n = 1'b0;
    rst_sml_n = 1'b0;
    k_def = 0; k_sml = 0;
    pend_def = 24'h0; pend_sml = 24'h0;
    bus_def.pixel_data = 24'h0;
    bus_sml.pixel_data = 24'h0;
    hold = 0;

    repeat (5) step();
    rst_def_n = 1'b1;
    rst_sml_n = 1'b1;

    // Run the default raster into its first active line; small raster gets random resets.
    for (int i = 0; i < 37575; i++) begin
      step();
      if (!rst_sml_n) begin
        if (hold == 0) rst_sml_n = 1'b1;
        else hold--;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_sml_n = 1'b0;
        hold = $urandom_range(0, 3);
      end
    end
    rst_sml_n = 1'b1;

    chk("def_mid_x_before_reset",  32'(bus_def.pixel_xpos), 32'd400);
    chk("def_mid_de_before_reset", 32'(bus_def.lcd_de),     32'd1);
    rst_def_n = 1'b0;
    #1;
    check_reset_now("def", bus_def.lcd_hs, bus_def.lcd_vs, bus_def.lcd_de, bus_def.lcd_rgb,
                    bus_def.frame_start, bus_def.pixel_xpos, bus_def.pixel_ypos);
    repeat (3) step();
    rst_def_n = 1'b1;
    repeat (3000) step();

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (bus_sml.pixel_xpos == 11'd4 && bus_sml.pixel_ypos == 11'd2) found = 1'b1;
    end
    chk("sml_find_pixel_4_2", 32'(found), 32'd1);
    rst_sml_n = 1'b0;
    #1;
    check_reset_now("sml", bus_sml.lcd_hs, bus_sml.lcd_vs, bus_sml.lcd_de, bus_sml.lcd_rgb,
                    bus_sml.frame_start, bus_sml.pixel_xpos, bus_sml.pixel_ypos);
    repeat (2) step();
    rst_sml_n = 1'b1;
    n = 0;
    rose = 1'b0;
    for (int i = 0; i < 200 && !rose; i++) begin
      step();
      n++;
      if (bus_sml.lcd_de) rose = 1'b1;
    end
    chk("sml_de_rise_after_release", 32'(n), 32'd39);
    repeat (300) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
